sata_write_padder: RTL and testbench

Parametrised block-alignment stage between the DAQ sample FIFO (first-word-fall-through read side) and the write-data port of `sata_control`. It passes each `RECORD_WORDS`-word sample record through unchanged, pads it with filler words to a `BLOCK_WORDS` boundary, and terminates write sessions on a block boundary. It also emits the per-block FIFO-count feedback strobe and keeps block and underrun statistics.

---
 rtl/sata_pkg.sv | 17 +
 rtl/sata_pad_stats.sv | 49 ++++
 rtl/sata_write_padder.sv | 140 ++++++++++++++
 tb/tb_sata_write_padder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_pkg.sv
// Shared definitions for the SATA write path: padder state encoding, the
// pad-marker tag and default record/block geometry.
package sata_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2
    } pad_state_e;

    localparam logic [7:0] MARKER_TAG = 8'hA5;

    localparam int DEF_RECORD_WORDS = 565;
    localparam int DEF_BLOCK_WORDS  = 1024;
    localparam int DEF_SECTOR_WORDS = 128;

endpackage

// File: rtl/sata_pad_stats.sv
// Block/underrun statistics and the registered per-block FIFO-count feedback
// strobe, driven by single-cycle events from the padder FSM.
module sata_pad_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        block_done_i,
    input  logic        underrun_i,
    input  logic        first_accept_i,
    output logic [31:0] block_count_o,
    output logic [15:0] underrun_count_o,
    output logic        strobe_o
);

    logic [31:0] block_count_q, block_count_d;
    logic [15:0] underrun_count_q, underrun_count_d;
    logic        strobe_q, strobe_d;

    always_comb begin
        block_count_d    = block_count_q;
        underrun_count_d = underrun_count_q;
        strobe_d         = first_accept_i;
        if (block_done_i) begin
            block_count_d = block_count_q + 32'd1;
        end
        // Saturate rather than wrap so a long stall stays visible.
        if (underrun_i && (underrun_count_q != 16'hFFFF)) begin
            underrun_count_d = underrun_count_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_count_q    <= '0;
            underrun_count_q <= '0;
            strobe_q         <= 1'b0;
        end else begin
            block_count_q    <= block_count_d;
            underrun_count_q <= underrun_count_d;
            strobe_q         <= strobe_d;
        end
    end

    assign block_count_o    = block_count_q;
    assign underrun_count_o = underrun_count_q;
    assign strobe_o         = strobe_q;

endmodule

// File: rtl/sata_write_padder.sv
// Pads DAQ sample records to block boundaries for sata_control and closes
// sessions on a block edge. Define SATA_PAD_MARKER_EN to tag the first pad word.
module sata_write_padder
    import sata_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    RECORD_WORDS = DEF_RECORD_WORDS,
    parameter int                    SECTOR_WORDS = DEF_SECTOR_WORDS,
    parameter int                    BLOCK_WORDS  = DEF_BLOCK_WORDS,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD     = '0
) (
    input  logic                           clk,
    input  logic                           RESET_N,
    input  logic                           write_enable,
    output logic                           daq_fifo_read_en,
    input  logic                           daq_fifo_empty,
    input  logic [DATA_WIDTH-1:0]          daq_fifo_data,
    input  logic                           sata_write_fifo_read_en,
    output logic                           sata_write_fifo_empty,
    output logic [DATA_WIDTH-1:0]          sata_write_fifo_data,
    output logic                           daq_fifo_feedback_count_strobe,
    output logic [$clog2(BLOCK_WORDS)-1:0] word_index,
    output logic [31:0]                    block_count,
    output logic [15:0]                    underrun_count,
    output logic [1:0]                     padder_state
);

    localparam int               IDX_W    = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] LAST_REC = IDX_W'(RECORD_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(BLOCK_WORDS - 1);

    if (DATA_WIDTH < 16) begin : g_bad_width
        $error("sata_write_padder: DATA_WIDTH must be >= 16");
    end
    if ((RECORD_WORDS < 1) || (RECORD_WORDS >= BLOCK_WORDS)) begin : g_bad_record
        $error("sata_write_padder: RECORD_WORDS must be in 1..BLOCK_WORDS-1");
    end
    if ((BLOCK_WORDS < 2) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0)) begin : g_bad_block
        $error("sata_write_padder: BLOCK_WORDS must be a power of two");
    end
    if ((SECTOR_WORDS < 1) || ((BLOCK_WORDS % SECTOR_WORDS) != 0)) begin : g_bad_sector
        $error("sata_write_padder: BLOCK_WORDS must be a multiple of SECTOR_WORDS");
    end

    pad_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  accept;
    logic [DATA_WIDTH-1:0] pad_data;

`ifdef SATA_PAD_MARKER_EN
    logic first_pad_q, first_pad_d;

    // The marker lands on whichever index the block starts padding at.
    assign pad_data = first_pad_q ? {MARKER_TAG, (DATA_WIDTH - 8)'(block_count)} : PAD_WORD;

    always_comb begin
        first_pad_d = first_pad_q;
        if ((state_q == ST_DATA) && (state_d == ST_PAD)) begin
            first_pad_d = 1'b1;
        end else if ((state_q == ST_PAD) && accept) begin
            first_pad_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            first_pad_q <= 1'b0;
        end else begin
            first_pad_q <= first_pad_d;
        end
    end
`else
    assign pad_data = PAD_WORD;
`endif

    assign sata_write_fifo_empty = (state_q == ST_DATA) ? daq_fifo_empty : 1'b0;
    assign accept                = sata_write_fifo_read_en && !sata_write_fifo_empty;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d              = state_q;
        idx_d                = idx_q;
        daq_fifo_read_en     = 1'b0;
        sata_write_fifo_data = pad_data;
        case (state_q)
            ST_IDLE: begin
                if (write_enable) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                daq_fifo_read_en     = sata_write_fifo_read_en;
                sata_write_fifo_data = daq_fifo_data;
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_REC) begin
                        state_d = ST_PAD;
                    end
                end else if (!write_enable && daq_fifo_empty) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_BLK) begin
                        state_d = write_enable ? ST_DATA : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    sata_pad_stats u_stats (
        .clk              (clk),
        .rst_n            (RESET_N),
        .block_done_i     ((state_q == ST_PAD) && accept && (idx_q == LAST_BLK)),
        .underrun_i       ((state_q == ST_DATA) && write_enable && sata_write_fifo_read_en && daq_fifo_empty),
        .first_accept_i   ((state_q == ST_DATA) && accept && (idx_q == '0)),
        .block_count_o    (block_count),
        .underrun_count_o (underrun_count),
        .strobe_o         (daq_fifo_feedback_count_strobe)
    );

    assign word_index   = idx_q;
    assign padder_state = state_q;

endmodule

// File: tb/tb_sata_write_padder.sv
// Scoreboard bench for sata_write_padder: a block-position reference model
// predicts every accepted word; a monitor compares them as the DUT presents them.
module tb_sata_write_padder;

    localparam int          DW   = 32;
    localparam int          RW   = 565;
    localparam int          SW   = 128;
    localparam int          BW   = 1024;
    localparam logic [31:0] PADW = 32'h0;

    logic          clk = 1'b0;
    logic          RESET_N = 1'b0;
    logic          write_enable = 1'b0;
    logic          daq_fifo_read_en;
    logic          daq_fifo_empty = 1'b0;
    logic [DW-1:0] daq_fifo_data;
    logic          sata_write_fifo_read_en = 1'b0;
    logic          sata_write_fifo_empty;
    logic [DW-1:0] sata_write_fifo_data;
    logic          daq_fifo_feedback_count_strobe;
    logic [9:0]    word_index;
    logic [31:0]   block_count;
    logic [15:0]   underrun_count;
    logic [1:0]    padder_state;

    logic [31:0]   fifo_head = 32'h0;
    assign daq_fifo_data = fifo_head;

    always #5 clk = ~clk;

    sata_write_padder #(
        .DATA_WIDTH   (DW),
        .RECORD_WORDS (RW),
        .SECTOR_WORDS (SW),
        .BLOCK_WORDS  (BW),
        .PAD_WORD     (PADW)
    ) dut (
        .clk                            (clk),
        .RESET_N                        (RESET_N),
        .write_enable                   (write_enable),
        .daq_fifo_read_en               (daq_fifo_read_en),
        .daq_fifo_empty                 (daq_fifo_empty),
        .daq_fifo_data                  (daq_fifo_data),
        .sata_write_fifo_read_en        (sata_write_fifo_read_en),
        .sata_write_fifo_empty          (sata_write_fifo_empty),
        .sata_write_fifo_data           (sata_write_fifo_data),
        .daq_fifo_feedback_count_strobe (daq_fifo_feedback_count_strobe),
        .word_index                     (word_index),
        .block_count                    (block_count),
        .underrun_count                 (underrun_count),
        .padder_state                   (padder_state)
    );

    typedef struct {
        logic [31:0] data;
        int          idx;
        bit          strobe_next;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   dut_strobes = 0;

    // Reference model: session active, position in block, real data finished.
    bit          m_sess = 0;
    bit          m_done = 0;
    bit          m_first_pad = 0;
    int          m_pos = 0;
    int unsigned m_blocks = 0;
    int          m_under = 0;
    // Model state as of the most recent clock edge (what the DUT now holds).
    int unsigned s_blocks = 0;
    int          s_under = 0;
    int          s_state = 0;
    int          s_pos = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] pad_value();
        logic [31:0] b;
        b = m_blocks;
`ifdef SATA_PAD_MARKER_EN
        if (m_first_pad) return {8'hA5, b[23:0]};
`endif
        return PADW;
    endfunction

    function automatic void push(input logic [31:0] d, input int idx, input bit strb);
        exp_t e;
        e.data = d;
        e.idx = idx;
        e.strobe_next = strb;
        sbq.push_back(e);
    endfunction

    // Predicts this cycle's accept from the driven inputs, then advances.
    function automatic void model_eval(input bit we, input bit rd, input bit fe);
        s_blocks = m_blocks;
        s_under  = m_under;
        s_pos    = m_pos;
        s_state  = !m_sess ? 0 : (!m_done ? 1 : 2);
        if (!m_sess) begin
            if (rd) push(pad_value(), 0, 1'b0);
            if (we) begin
                m_sess = 1;
                m_pos  = 0;
                m_done = 0;
            end
        end else if (!m_done) begin
            if (we && rd && fe && m_under < 65535) m_under++;
            if (rd && !fe) begin
                push(fifo_head, m_pos, m_pos == 0);
                m_pos++;
                if (m_pos == RW) begin
                    m_done = 1;
                    m_first_pad = 1;
                end
            end else if (!we && fe) begin
                m_done = 1;
                m_first_pad = 1;
            end
        end else if (rd) begin
            push(pad_value(), m_pos, 1'b0);
            m_first_pad = 0;
            if (m_pos == BW - 1) begin
                m_blocks++;
                m_pos  = 0;
                m_done = 0;
                m_sess = we;
            end else begin
                m_pos++;
            end
        end
    endfunction

    // One clock: FIFO reacts to the DUT's pop, then new inputs are driven.
    task automatic step(input bit we, input bit rd, input bit starve);
        bit pop;
        @(negedge clk);
        pop = daq_fifo_read_en && !daq_fifo_empty;
        @(posedge clk);
        #1;
        if (pop) fifo_head = $urandom();
        write_enable = we;
        sata_write_fifo_read_en = rd;
        daq_fifo_empty = starve;
        model_eval(we, rd, starve);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_blocks"}, block_count, s_blocks);
        check({tag, "_underrun"}, {16'h0, underrun_count}, s_under);
        check({tag, "_state"}, {30'h0, padder_state}, s_state);
        check({tag, "_index"}, {22'h0, word_index}, s_pos);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, {30'h0, padder_state}, 32'd0);
        check({tag, "_index"}, {22'h0, word_index}, 32'd0);
        check({tag, "_blocks"}, block_count, 32'd0);
        check({tag, "_underrun"}, {16'h0, underrun_count}, 32'd0);
        check({tag, "_strobe"}, {31'h0, daq_fifo_feedback_count_strobe}, 32'd0);
        check({tag, "_empty"}, {31'h0, sata_write_fifo_empty}, 32'd0);
        check({tag, "_data"}, sata_write_fifo_data, PADW);
        check({tag, "_rden"}, {31'h0, daq_fifo_read_en}, 32'd0);
    endtask

    // Monitor: pops one expectation per DUT accept and tracks the strobe.
    initial begin
        exp_t e;
        bit   exp_strobe;
        exp_strobe = 0;
        forever begin
            @(negedge clk);
            if (!RESET_N) exp_strobe = 0;
            check("strobe", {31'h0, daq_fifo_feedback_count_strobe}, {31'h0, exp_strobe});
            if (daq_fifo_feedback_count_strobe) dut_strobes++;
            exp_strobe = 0;
            if (RESET_N && sata_write_fifo_read_en && !sata_write_fifo_empty) begin
                if (sbq.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("accept_data", sata_write_fifo_data, e.data);
                    check("accept_index", {22'h0, word_index}, e.idx);
                    exp_strobe = e.strobe_next;
                end
            end
        end
    end

    initial begin
        bit          pop;
        bit          ok;
        int unsigned blk_before;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        RESET_N = 1'b1;
        fifo_head = $urandom();

        // Full FIFO, continuous reads: two complete blocks.
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1, 1, 0);
            if (m_blocks == 2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("two_blocks");
        step(1, 0, 0);
        check_state("after_2_blocks");
        check("blocks_2", block_count, 32'd2);
        check("strobes_2", dut_strobes, 32'd2);

        // Starve the FIFO for 10 read cycles at index 100.
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1, 1, 0);
            if (m_sess && !m_done && m_pos == 100) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("reach_idx100");
        repeat (10) step(1, 1, 1);
        step(1, 0, 0);
        check("underrun_10", {16'h0, underrun_count}, 32'd10);
        check("resume_idx100", {22'h0, word_index}, 32'd100);

        // Random reads and FIFO availability.
        for (int i = 0; i < 4000; i++) begin
            step(1, ($urandom % 4) != 0, ($urandom % 5) == 0);
        end
        step(1, 0, 0);
        check_state("random");

        // Flush: drop write_enable at index 300 with the FIFO empty.
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1, 1, 0);
            if (m_sess && !m_done && m_pos == 300) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("reach_idx300");
        blk_before = m_blocks;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            step(0, 1, 1);
            if (!m_sess) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("flush_to_idle");
        step(0, 0, 0);
        check("flush_idle", {30'h0, padder_state}, 32'd0);
        check("flush_blocks", block_count, blk_before + 1);
        repeat (5) step(0, 1, 0);
        step(0, 0, 0);
        check_state("idle_drain");

        // Reset in the middle of a block at index 700.
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1, 1, 0);
            if (m_sess && m_pos == 700) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("reach_idx700");
        @(negedge clk);
        pop = daq_fifo_read_en && !daq_fifo_empty;
        @(posedge clk);
        #1;
        if (pop) fifo_head = $urandom();
        sata_write_fifo_read_en = 1'b0;
        write_enable = 1'b0;
        daq_fifo_empty = 1'b0;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sbq.delete();
        m_sess = 0; m_done = 0; m_first_pad = 0; m_pos = 0; m_blocks = 0; m_under = 0;
        repeat (3) @(negedge clk);
        RESET_N = 1'b1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step(1, 1, 0);
            if (m_blocks == 1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bound_fail("post_reset_block");
        step(1, 0, 0);
        check("post_reset_blocks", block_count, 32'd1);

        // Long underrun: counter saturates.
        repeat (70000) step(1, 1, 1);
        step(1, 0, 0);
        check("underrun_sat", {16'h0, underrun_count}, 32'h0000FFFF);
        check_state("saturated");

        repeat (3) step(0, 0, 0);
        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
